sm_reg_uart_dump: RTL and testbench
===================================

// Module: sm_reg_uart_dump
//
// PURPOSE
//  Sits directly downstream of sm_top and consumes its regData debug output.
//  Sends the watched register value as 8 upper-case hex ASCII chars plus CR LF
//  ("0000ABCD\r\n") on a UART TX line. A dump starts on any change of regData
//  or on a force pulse, so register contents can be read on a PC terminal.
//
// PARAMETERS
//  BAUD_DIV  87  clk cycles per UART bit (10 MHz / 115200); legal range 2..65535
//  WIDTH     32  regData width; must be a multiple of 4; nibbles sent = WIDTH/4
//
// PORTS
//  clk       in   1      single clock, same clock that drives sm_top
//  rst_p     in   1      synchronous, active-high reset
//  regData   in   WIDTH  watched value from sm_top
//  force     in   1      one-cycle request: dump now, even if unchanged
//  uart_tx   out  1      serial line, 8N1, LSB first, idle high
//  busy      out  1      high from frame start to end of last stop bit
//  dumpCnt   out  16     number of completed dumps, wraps at 0xFFFF
//
// BEHAVIOUR
//  Reset (rst_p high at a clk edge):
//   - uart_tx=1, busy=0, dumpCnt=0, state=IDLE.
//   - lastSent=0 and pending=0.
//   - Reset mid-frame aborts the frame at once; the line returns high next cycle.
//  Trigger (sampled each edge): trig = force | (regData != lastSent).
//  IDLE:
//   - On trig: snap<=regData, lastSent<=regData, chr<=0, bit timer<=0.
//   - Same edge: uart_tx<=0 (start bit) and busy<=1. Latency is 1 clk.
//  START: hold 0 for BAUD_DIV cycles, then go to DATA.
//  DATA: 8 bits, LSB first, each held BAUD_DIV cycles, then go to STOP.
//  STOP: hold 1 for BAUD_DIV cycles, then go to NEXT.
//  NEXT (1 clk):
//   - If chr<9: chr++ and emit the next start bit.
//   - If chr==9: frame done, dumpCnt++, busy<=0.
//  Char map:
//   - chr 0..7 = nibble snap[31-4*chr -: 4], MSB nibble first.
//   - Nibble n<10 -> 8'h30+n; n>=10 -> 8'h41+n-10. chr 8 = 8'h0D, chr 9 = 8'h0A.
//  Frame timing:
//   - Char period = 10*BAUD_DIV+1 clks (the +1 is the NEXT cycle).
//   - busy high for 10*(10*BAUD_DIV+1) clks.
//  Changes while busy:
//   - snap is frozen; a frame always sends the value captured at its start.
//   - force while busy sets pending=1.
//   - At frame end, if pending or regData!=lastSent, the next frame starts after
//     exactly 1 idle clk (uart_tx=1). pending is then cleared.
//   - Intermediate values are dropped; only the latest value is dumped.
//  Simultaneous force and regData change count as one trigger.
//  dumpCnt wraps 0xFFFF->0x0000 silently.
//
// TESTING (BAUD_DIV=4)
//  1. Reset held 3 clks with regData=0, then released.
//     -> uart_tx=1, busy=0 and dumpCnt=0 for 50 clks; no frame sent.
//  2. regData=32'h0000ABCD.
//     -> start bit 1 clk later; UART model decodes "0000ABCD\r\n".
//     -> busy high for exactly 410 clks; dumpCnt=1.
//  3. regData 1->2->3 during a frame.
//     -> second frame starts 1 clk after the first ends and sends "00000003".
//     -> dumpCnt increments by 2 in total.
//  4. force pulsed with regData stable at 32'hDEADBEEF.
//     -> "DEADBEEF\r\n" is re-sent; force during busy gives exactly one more frame.
//  5. rst_p asserted mid DATA bit of char 4.
//     -> next clk: uart_tx=1, busy=0, dumpCnt=0; nonzero regData re-dumps after release.
//  6. Preload dumpCnt to 0xFFFF via 65535 forced dumps (or a hierarchical force),
//     then one more dump. -> dumpCnt=0x0000.

Source files
------------

// File: rtl/sm_reg_uart_dump.sv
// Dumps a watched register as 8 hex ASCII chars plus CR LF over an 8N1 UART line.
// A dump starts on any change of regData or on a force request; only the latest value is sent.
module sm_reg_uart_dump #(
    parameter int BAUD_DIV = 87,
    parameter int WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst_p,
    input  logic [WIDTH-1:0] regData,
    input  logic             force_dump,
    output logic             uart_tx,
    output logic             busy,
    output logic [15:0]      dumpCnt
);

    localparam int NIB      = WIDTH / 4;
    localparam int LAST_CHR = NIB + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

    state_t           state;
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] last_sent;
    logic             pending;
    logic [7:0]       chr;
    logic [15:0]      timer;
    logic [2:0]       bit_idx;
    logic [7:0]       cur_char;
    logic [WIDTH-1:0] shifted;
    logic             trig;
    logic             bit_end;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        trig    = force_dump | pending | (regData != last_sent);
        bit_end = (timer == 16'(BAUD_DIV - 1));
    end

    // Character being sent: hex nibbles MSB first, then CR, then LF.
    always_comb begin
        cur_char = 8'h0A;
        shifted  = '0;
        if (int'(chr) < NIB) begin
            shifted  = snap >> (4 * (NIB - 1 - int'(chr)));
            cur_char = hex_char(shifted[3:0]);
        end else if (int'(chr) == NIB) begin
            cur_char = 8'h0D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state     <= IDLE;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            dumpCnt   <= 16'd0;
            last_sent <= '0;
            pending   <= 1'b0;
            chr       <= 8'd0;
            timer     <= 16'd0;
            bit_idx   <= 3'd0;
        end else begin
            // A force arriving mid-frame is remembered and served after the frame.
            if (state != IDLE && force_dump)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (trig) begin
                        snap      <= regData;
                        last_sent <= regData;
                        pending   <= 1'b0;
                        chr       <= 8'd0;
                        timer     <= 16'd0;
                        uart_tx   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= 16'd0;
                        bit_idx <= 3'd0;
                        uart_tx <= cur_char[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= cur_char[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= 16'd0;
                        state <= NEXT;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                NEXT: begin
                    if (chr == 8'(LAST_CHR)) begin
                        dumpCnt <= dumpCnt + 16'd1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        chr     <= chr + 8'd1;
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_reg_uart_dump.sv
// Directed bench for sm_reg_uart_dump at BAUD_DIV=4: decodes the UART line and
// checks framing, busy timing, retrigger behaviour, reset abort and counter wrap.
module tb_sm_reg_uart_dump;

    logic        clk = 1'b0;
    logic        rst_p;
    logic [31:0] regData;
    logic        force_dump;
    logic        uart_tx;
    logic        busy;
    logic [15:0] dumpCnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sm_reg_uart_dump #(.BAUD_DIV(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .regData   (regData),
        .force_dump(force_dump),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .dumpCnt   (dumpCnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_force();
        force_dump = 1'b1;
        tick();
        force_dump = 1'b0;
    endtask

    // Receive one 8N1 byte; samples the middle of each 4-clk bit.
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        int n = 0;
        b  = 8'h00;
        ok = 1'b1;
        while (uart_tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            ok = 1'b0;
            return;
        end
        repeat (2) tick();
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            b[i] = uart_tx;
        end
        repeat (4) tick();
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic rx_frame(input string tag, input string text);
        logic [7:0] b;
        logic [7:0] exp;
        bit         ok;
        for (int i = 0; i < 10; i++) begin
            exp = (i < 8) ? 8'(text[i]) : ((i == 8) ? 8'h0D : 8'h0A);
            rx_byte(b, ok);
            check($sformatf("%s_framing%0d", tag, i), {31'd0, ok}, 32'd1);
            check($sformatf("%s_char%0d", tag, i), {24'd0, b}, {24'd0, exp});
        end
    endtask

    task automatic wait_idle(input string tag, output int t);
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        t = cyc;
        if (n >= 1000) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int t0, t1, bad, cnt0;
        rst_p      = 1'b1;
        regData    = 32'h0;
        force_dump = 1'b0;

        // 1: reset, then quiet line
        repeat (3) tick();
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnt", {16'd0, dumpCnt}, 32'd0);
        rst_p = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0 || dumpCnt !== 16'd0) bad++;
        end
        check("idle_quiet", bad, 32'd0);

        // 2: single dump, latency and busy length
        regData = 32'h0000ABCD;
        tick();
        check("lat_tx", {31'd0, uart_tx}, 32'd0);
        check("lat_busy", {31'd0, busy}, 32'd1);
        t0 = cyc;
        rx_frame("abcd", "0000ABCD");
        wait_idle("abcd", t1);
        check("busy_len", t1 - t0, 32'd410);
        check("cnt_1", {16'd0, dumpCnt}, 32'd1);

        // 3: value changes mid-frame collapse to the latest
        tick();
        regData = 32'h1;
        fork
            rx_frame("v1", "00000001");
            begin
                repeat (50) tick();
                regData = 32'h2;
                repeat (50) tick();
                regData = 32'h3;
            end
        join
        wait_idle("v1", t1);
        check("gap_tx", {31'd0, uart_tx}, 32'd1);
        tick();
        check("gap_busy", {31'd0, busy}, 32'd1);
        check("gap_start", {31'd0, uart_tx}, 32'd0);
        rx_frame("v3", "00000003");
        wait_idle("v3", t1);
        check("cnt_3", {16'd0, dumpCnt}, 32'd3);

        // 4: force re-dump, forces during busy give one extra frame
        regData = 32'hDEADBEEF;
        rx_frame("dead0", "DEADBEEF");
        wait_idle("dead0", t1);
        check("cnt_4", {16'd0, dumpCnt}, 32'd4);
        repeat (20) tick();
        check("no_spurious", {31'd0, busy}, 32'd0);
        pulse_force();
        check("force_busy", {31'd0, busy}, 32'd1);
        fork
            rx_frame("dead1", "DEADBEEF");
            begin
                repeat (30) tick();
                pulse_force();
                repeat (30) tick();
                pulse_force();
            end
        join
        wait_idle("dead1", t1);
        tick();
        check("pend_busy", {31'd0, busy}, 32'd1);
        rx_frame("dead2", "DEADBEEF");
        wait_idle("dead2", t1);
        check("cnt_6", {16'd0, dumpCnt}, 32'd6);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0) bad++;
        end
        check("pend_once", bad, 32'd0);

        // 5: reset mid DATA bit of char 4
        regData = 32'h12345678;
        tick();
        check("r5_start", {31'd0, busy}, 32'd1);
        repeat (180) tick();
        rst_p = 1'b1;
        tick();
        check("abort_tx", {31'd0, uart_tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cnt", {16'd0, dumpCnt}, 32'd0);
        rst_p = 1'b0;
        tick();
        check("redump_busy", {31'd0, busy}, 32'd1);
        rx_frame("r5", "12345678");
        wait_idle("r5", t1);
        check("cnt_r5", {16'd0, dumpCnt}, 32'd1);

        // 6: counter wrap
        tick();
        force dut.dumpCnt = 16'hFFFF;
        #2;
        release dut.dumpCnt;
        cnt0 = dumpCnt;
        check("preload", cnt0, 32'hFFFF);
        tick();
        pulse_force();
        check("wrap_busy", {31'd0, busy}, 32'd1);
        wait_idle("wrap", t1);
        check("wrap_cnt", {16'd0, dumpCnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
